// File: rtl/jcs_cpu_pkg.sv
// Shared constants for the 8-bit Scott-style CPU: ALU function codes,
// non-ALU instruction classes (IR[6:4] when IR[7]=0) and flag bit indices.
package jcs_cpu_pkg;

    // ALU function codes, IR[6:4] when IR[7]=1
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SHR = 3'd1;
    localparam logic [2:0] ALU_SHL = 3'd2;
    localparam logic [2:0] ALU_NOT = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_XOR = 3'd6;
    localparam logic [2:0] ALU_CMP = 3'd7;

    // Non-ALU instruction classes, IR[6:4] when IR[7]=0
    localparam logic [2:0] OP_LD    = 3'd0;
    localparam logic [2:0] OP_ST    = 3'd1;
    localparam logic [2:0] OP_DATA  = 3'd2;
    localparam logic [2:0] OP_JMPR  = 3'd3;
    localparam logic [2:0] OP_JMP   = 3'd4;
    localparam logic [2:0] OP_JCAEZ = 3'd5;
    localparam logic [2:0] OP_CLF   = 3'd6;
    localparam logic [2:0] OP_IO    = 3'd7;

    // Bit positions inside flags_bus {C,A,E,Z}
    localparam int FLG_C = 3;
    localparam int FLG_A = 2;
    localparam int FLG_E = 1;
    localparam int FLG_Z = 0;

    // One-hot register select from a 2-bit register field
    function automatic logic [3:0] reg_sel(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/jcs_ir_decoder.sv
// Instruction register decoder: one-hot instruction class plus one-hot
// RA (IR[3:2]) and RB (IR[1:0]) register selects.
// Macro JCU_IO_EN: when undefined, class 0111xxxx never decodes as IO and
// falls through to a NOP after fetch.
import jcs_cpu_pkg::*;

module jcs_ir_decoder #(
    parameter logic [7:0] HALT_OPCODE = 8'h61
) (
    input  logic [7:0] ir_i,
    output logic       is_alu_o,
    output logic       is_ld_o,
    output logic       is_st_o,
    output logic       is_data_o,
    output logic       is_jmpr_o,
    output logic       is_jmp_o,
    output logic       is_jcaez_o,
    output logic       is_clf_o,
    output logic       is_halt_o,
    output logic       is_io_o,
    output logic [3:0] ra_sel_o,
    output logic [3:0] rb_sel_o
);

    assign ra_sel_o = reg_sel(ir_i[3:2]);
    assign rb_sel_o = reg_sel(ir_i[1:0]);

    // Class decode; halt opcode wins over its class, anything else undecoded is a NOP
    always_comb begin
        is_alu_o   = 1'b0;
        is_ld_o    = 1'b0;
        is_st_o    = 1'b0;
        is_data_o  = 1'b0;
        is_jmpr_o  = 1'b0;
        is_jmp_o   = 1'b0;
        is_jcaez_o = 1'b0;
        is_clf_o   = 1'b0;
        is_halt_o  = 1'b0;
        is_io_o    = 1'b0;
        if (ir_i == HALT_OPCODE) begin
            is_halt_o = 1'b1;
        end else if (ir_i[7]) begin
            is_alu_o = 1'b1;
        end else begin
            case (ir_i[6:4])
                OP_LD:    is_ld_o    = 1'b1;
                OP_ST:    is_st_o    = 1'b1;
                OP_DATA:  is_data_o  = 1'b1;
                OP_JMPR:  is_jmpr_o  = 1'b1;
                OP_JMP:   is_jmp_o   = 1'b1;
                OP_JCAEZ: is_jcaez_o = 1'b1;
                OP_CLF:   is_clf_o   = (ir_i[3:0] == 4'h0);
`ifdef JCU_IO_EN
                OP_IO:    is_io_o    = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/jcs_control_unit.sv
// Control unit: turns IR class, one-hot stepper and clock phases into the
// datapath strobes. Everything is combinational except the sticky halt flag.
// Macro JCU_IO_EN: enables IO instruction decode (io_* outputs stay 0 otherwise).
import jcs_cpu_pkg::*;

module jcs_control_unit #(
    parameter logic [7:0] HALT_OPCODE = 8'h61
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       CLK_clk,
    input  logic       CLK_clkd,
    input  logic       CLK_clke,
    input  logic       CLK_clks,
    input  logic [0:5] STP_bus,
    input  logic [3:0] flags_bus,
    input  logic [7:0] ir_bus,
    output logic [2:0] alu_op,
    output logic       alu_ena_ci,
    output logic       flags_s,
    output logic       tmp_s,
    output logic       bus1_bit1,
    output logic       acc_s,
    output logic       acc_e,
    output logic       r0_s,
    output logic       r0_e,
    output logic       r1_s,
    output logic       r1_e,
    output logic       r2_s,
    output logic       r2_e,
    output logic       r3_s,
    output logic       r3_e,
    output logic       ram_mar_s,
    output logic       ram_s,
    output logic       ram_e,
    output logic       iar_s,
    output logic       iar_e,
    output logic       ir_s,
    output logic       halt,
    output logic       io_s,
    output logic       io_e,
    output logic       io_da,
    output logic       io_io
);

    logic       is_alu, is_ld, is_st, is_data, is_jmpr, is_jmp, is_jcaez, is_clf, is_halt, is_io;
    logic [3:0] ra_sel, rb_sel;
    logic       halt_q, halt_d;
    logic [6:1] stp_b, stp_e, stp_s;
    logic [3:0] reg_e_d, reg_s_d;
    logic       unused_phase;

    // The base and delayed phases exist only for interface compatibility
    assign unused_phase = CLK_clk ^ CLK_clkd;

    jcs_ir_decoder #(.HALT_OPCODE(HALT_OPCODE)) u_dec (
        .ir_i       (ir_bus),
        .is_alu_o   (is_alu),
        .is_ld_o    (is_ld),
        .is_st_o    (is_st),
        .is_data_o  (is_data),
        .is_jmpr_o  (is_jmpr),
        .is_jmp_o   (is_jmp),
        .is_jcaez_o (is_jcaez),
        .is_clf_o   (is_clf),
        .is_halt_o  (is_halt),
        .is_io_o    (is_io),
        .ra_sel_o   (ra_sel),
        .rb_sel_o   (rb_sel)
    );

    // Per-step windows; halt kills every strobe at the source
    always_comb begin
        stp_b = '0;
        for (int n = 1; n <= 6; n++) stp_b[n] = STP_bus[n-1] & ~halt_q;
    end
    assign stp_e = stp_b & {6{CLK_clke}};
    assign stp_s = stp_b & {6{CLK_clks}};

    // Strobe decode: fetch terms first, then OR in the per-class terms
    always_comb begin
        alu_op     = ALU_ADD;
        alu_ena_ci = 1'b0;
        flags_s    = 1'b0;
        tmp_s      = 1'b0;
        ram_s      = 1'b0;
        io_s       = 1'b0;
        io_e       = 1'b0;
        io_da      = 1'b0;
        io_io      = 1'b0;
        reg_e_d    = '0;
        reg_s_d    = '0;
        bus1_bit1  = stp_b[1];
        iar_e      = stp_e[1];
        ram_mar_s  = stp_s[1];
        acc_s      = stp_s[1];
        ram_e      = stp_e[2];
        ir_s       = stp_s[2];
        acc_e      = stp_e[3];
        iar_s      = stp_s[3];

        if (is_alu) begin
            reg_e_d |= rb_sel & {4{stp_e[4]}};
            tmp_s   |= stp_s[4];
            reg_e_d |= ra_sel & {4{stp_e[5]}};
            acc_s   |= stp_s[5];
            flags_s |= stp_s[5];
            if (STP_bus[4]) begin
                alu_op     = ir_bus[6:4];
                alu_ena_ci = (ir_bus[6:4] == ALU_ADD) || (ir_bus[6:4] == ALU_SHR) ||
                             (ir_bus[6:4] == ALU_SHL);
            end
            // CMP only updates flags; the result is never written back
            if (ir_bus[6:4] != ALU_CMP) begin
                acc_e   |= stp_e[6];
                reg_s_d |= rb_sel & {4{stp_s[6]}};
            end
        end
        if (is_ld) begin
            reg_e_d   |= ra_sel & {4{stp_e[4]}};
            ram_mar_s |= stp_s[4];
            ram_e     |= stp_e[5];
            reg_s_d   |= rb_sel & {4{stp_s[5]}};
        end
        if (is_st) begin
            reg_e_d   |= ra_sel & {4{stp_e[4]}};
            ram_mar_s |= stp_s[4];
            reg_e_d   |= rb_sel & {4{stp_e[5]}};
            ram_s     |= stp_s[5];
        end
        // DATA and JCAEZ both fetch an inline byte via the IAR+1 path
        if (is_data || is_jcaez) begin
            bus1_bit1 |= stp_b[4];
            iar_e     |= stp_e[4];
            ram_mar_s |= stp_s[4];
            acc_s     |= stp_s[4];
        end
        if (is_data) begin
            ram_e   |= stp_e[5];
            reg_s_d |= rb_sel & {4{stp_s[5]}};
            acc_e   |= stp_e[6];
            iar_s   |= stp_s[6];
        end
        if (is_jcaez) begin
            acc_e |= stp_e[5];
            iar_s |= stp_s[5];
            ram_e |= stp_e[6];
            if ((flags_bus & ir_bus[3:0]) != 4'h0) iar_s |= stp_s[6];
        end
        if (is_jmpr) begin
            reg_e_d |= rb_sel & {4{stp_e[4]}};
            iar_s   |= stp_s[4];
        end
        if (is_jmp) begin
            iar_e     |= stp_e[4];
            ram_mar_s |= stp_s[4];
            ram_e     |= stp_e[5];
            iar_s     |= stp_s[5];
        end
        // CLF: ADD with carry-in disabled and bus1 asserted clears the flags
        if (is_clf) begin
            bus1_bit1 |= stp_b[4];
            flags_s   |= stp_s[4];
        end
        if (is_io) begin
            io_io = ir_bus[3] & (STP_bus[3] | STP_bus[4] | STP_bus[5]);
            io_da = ir_bus[2] & (STP_bus[3] | STP_bus[4] | STP_bus[5]);
            if (ir_bus[3]) begin
                reg_e_d |= rb_sel & {4{stp_e[4]}};
                io_s    |= stp_s[4];
            end else begin
                io_e    |= stp_e[5];
                reg_s_d |= rb_sel & {4{stp_s[5]}};
            end
        end
    end

    assign {r3_e, r2_e, r1_e, r0_e} = reg_e_d;
    assign {r3_s, r2_s, r1_s, r0_s} = reg_s_d;

    // Halt latches on the step-4 set pulse of the halt opcode
    assign halt_d = halt_q | (is_halt & STP_bus[3] & CLK_clks);

    // Sticky halt register, cleared only by reset
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) halt_q <= 1'b0;
        else       halt_q <= halt_d;
    end

    assign halt = halt_q;

endmodule

// File: tb/tb_jcs_control_unit.sv
// Self-checking bench for jcs_control_unit: directed steps from the test plan
// followed by randomized IR/step/phase/flag vectors against a reference model.
module tb_jcs_control_unit;

    logic       CLK = 1'b0, reset, CLK_clk, CLK_clkd, CLK_clke, CLK_clks;
    logic [0:5] STP_bus;
    logic [3:0] flags_bus;
    logic [7:0] ir_bus;
    logic [2:0] alu_op;
    logic alu_ena_ci, flags_s, tmp_s, bus1_bit1, acc_s, acc_e;
    logic r0_s, r0_e, r1_s, r1_e, r2_s, r2_e, r3_s, r3_e;
    logic ram_mar_s, ram_s, ram_e, iar_s, iar_e, ir_s, halt;
    logic io_s, io_e, io_da, io_io;

    int   tests = 0, fails = 0;
    logic halt_m = 1'b0;

    localparam logic [26:0] BUS1_M = 27'h1 << 20;

    always #5 CLK = ~CLK;

    jcs_control_unit dut (
        .CLK(CLK), .reset(reset), .CLK_clk(CLK_clk), .CLK_clkd(CLK_clkd),
        .CLK_clke(CLK_clke), .CLK_clks(CLK_clks), .STP_bus(STP_bus),
        .flags_bus(flags_bus), .ir_bus(ir_bus), .alu_op(alu_op),
        .alu_ena_ci(alu_ena_ci), .flags_s(flags_s), .tmp_s(tmp_s),
        .bus1_bit1(bus1_bit1), .acc_s(acc_s), .acc_e(acc_e),
        .r0_s(r0_s), .r0_e(r0_e), .r1_s(r1_s), .r1_e(r1_e),
        .r2_s(r2_s), .r2_e(r2_e), .r3_s(r3_s), .r3_e(r3_e),
        .ram_mar_s(ram_mar_s), .ram_s(ram_s), .ram_e(ram_e),
        .iar_s(iar_s), .iar_e(iar_e), .ir_s(ir_s), .halt(halt),
        .io_s(io_s), .io_e(io_e), .io_da(io_da), .io_io(io_io)
    );

    function automatic logic [26:0] obs_vec();
        return {alu_op, alu_ena_ci, flags_s, tmp_s, bus1_bit1, acc_s, acc_e,
                r3_s, r2_s, r1_s, r0_s, r3_e, r2_e, r1_e, r0_e,
                ram_mar_s, ram_s, ram_e, iar_s, iar_e, ir_s, io_s, io_e, io_da, io_io};
    endfunction

    // Reference: list what each instruction wants in each step, then apply phase gating
    function automatic logic [26:0] model(input logic [7:0] ir, input int st, input logic ce,
                                          input logic cs, input logic [3:0] fl, input logic hl);
        logic b1, accS, accE, tmpS, flS, marS, ramS, ramE, iarS, iarE, irS, ioS, ioE, da, io, ci;
        logic [2:0] op;
        logic [3:0] rE, rS;
        logic en, set;
        int f, ra, rb;
        {b1, accS, accE, tmpS, flS, marS, ramS, ramE, iarS, iarE, irS, ioS, ioE, da, io, ci} = '0;
        op = 3'd0; rE = '0; rS = '0;
        f = int'(ir[6:4]); ra = int'(ir[3:2]); rb = int'(ir[1:0]);
        if (st == 1) begin b1 = 1; iarE = 1; marS = 1; accS = 1; end
        else if (st == 2) begin ramE = 1; irS = 1; end
        else if (st == 3) begin accE = 1; iarS = 1; end
        else if (ir[7]) begin
            if (st == 4) begin rE[rb] = 1; tmpS = 1; end
            if (st == 5) begin rE[ra] = 1; accS = 1; flS = 1; op = ir[6:4]; ci = (f < 3); end
            if (st == 6 && f != 7) begin accE = 1; rS[rb] = 1; end
        end else if (ir != 8'h61) begin
            case (f)
                0: begin
                    if (st == 4) begin rE[ra] = 1; marS = 1; end
                    if (st == 5) begin ramE = 1; rS[rb] = 1; end
                end
                1: begin
                    if (st == 4) begin rE[ra] = 1; marS = 1; end
                    if (st == 5) begin rE[rb] = 1; ramS = 1; end
                end
                2: begin
                    if (st == 4) begin b1 = 1; iarE = 1; marS = 1; accS = 1; end
                    if (st == 5) begin ramE = 1; rS[rb] = 1; end
                    if (st == 6) begin accE = 1; iarS = 1; end
                end
                3: if (st == 4) begin rE[rb] = 1; iarS = 1; end
                4: begin
                    if (st == 4) begin iarE = 1; marS = 1; end
                    if (st == 5) begin ramE = 1; iarS = 1; end
                end
                5: begin
                    if (st == 4) begin b1 = 1; iarE = 1; marS = 1; accS = 1; end
                    if (st == 5) begin accE = 1; iarS = 1; end
                    if (st == 6) begin ramE = 1; iarS = ((fl & ir[3:0]) != 0); end
                end
                6: if (ir[3:0] == 0 && st == 4) begin b1 = 1; flS = 1; end
                default: begin
`ifdef JCU_IO_EN
                    if (st >= 4) begin io = ir[3]; da = ir[2]; end
                    if (ir[3] && st == 4) begin rE[rb] = 1; ioS = 1; end
                    if (!ir[3] && st == 5) begin ioE = 1; rS[rb] = 1; end
`endif
                end
            endcase
        end
        en  = ce & ~hl;
        set = cs & ~hl;
        return {op, ci, flS & set, tmpS & set, b1 & ~hl, accS & set, accE & en,
                rS & {4{set}}, rE & {4{en}}, marS & set, ramS & set, ramE & en,
                iarS & set, iarE & en, irS & set, ioS & set, ioE & en, da, io};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic drive(input logic [7:0] ir, input int st, input logic ce, input logic cs,
                         input logic [3:0] fl);
        @(negedge CLK);
        ir_bus = ir; STP_bus = '0; STP_bus[st-1] = 1'b1;
        CLK_clke = ce; CLK_clks = cs; flags_bus = fl;
        CLK_clk = 1'($urandom); CLK_clkd = 1'($urandom);
        #1;
    endtask

    // Full-vector compare; bus1_bit1 is only compared inside the enable window
    task automatic check_all(input string tag, input logic [7:0] ir, input int st,
                             input logic ce, input logic cs, input logic [3:0] fl);
        logic [26:0] o, e;
        o = obs_vec();
        e = model(ir, st, ce, cs, fl, halt_m);
        if (!ce) begin o &= ~BUS1_M; e &= ~BUS1_M; end
        chk(tag, {5'd0, o}, {5'd0, e});
    endtask

    task automatic step(input string tag, input logic [7:0] ir, input int st, input logic ce,
                        input logic cs, input logic [3:0] fl);
        drive(ir, st, ce, cs, fl);
        check_all(tag, ir, st, ce, cs, fl);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rir;
        int         rst;
        reset = 1'b1; CLK_clk = 0; CLK_clkd = 0; CLK_clke = 0; CLK_clks = 0;
        STP_bus = '0; flags_bus = '0; ir_bus = '0;
        #12;
        chk("reset_halt", {31'd0, halt}, 32'd0);
        @(negedge CLK); reset = 1'b0;

        // Fetch
        for (int s = 1; s <= 3; s++) step($sformatf("fetch_s%0d", s), 8'h81, s, 1, 1, 4'h0);
        drive(8'h81, 1, 1, 1, 4'h0);
        chk("fetch_s1_bits", {28'd0, iar_e, bus1_bit1, ram_mar_s, acc_s}, 32'hF);
        step("fetch_s1_noclks", 8'h81, 1, 1, 0, 4'h0);
        chk("fetch_s1_noclks_mar", {31'd0, ram_mar_s}, 32'd0);
        drive(8'h33, 2, 0, 1, 4'h0);
        chk("fetch_s2_irs", {31'd0, ir_s}, 32'd1);

        // ADD R0,R1
        step("add_s4", 8'h81, 4, 1, 1, 4'h0);
        chk("add_s4_bits", {30'd0, r1_e, tmp_s}, 32'h3);
        step("add_s5", 8'h81, 5, 1, 1, 4'h0);
        chk("add_s5_op", {28'd0, alu_op, alu_ena_ci}, 32'h1);
        step("add_s6", 8'h81, 6, 1, 1, 4'h0);
        chk("add_s6_bits", {30'd0, acc_e, r1_s}, 32'h3);

        // CMP
        step("cmp_s5", 8'hF1, 5, 1, 1, 4'h0);
        chk("cmp_s5_op", {28'd0, alu_op, alu_ena_ci}, 32'hE);
        step("cmp_s6", 8'hF1, 6, 1, 1, 4'h0);
        chk("cmp_s6_none", {5'd0, obs_vec()}, 32'd0);

        // JC/JA
        step("jca_taken", 8'h5C, 6, 1, 1, 4'b1000);
        chk("jca_taken_bits", {30'd0, ram_e, iar_s}, 32'h3);
        step("jca_not", 8'h5C, 6, 1, 1, 4'b0011);
        chk("jca_not_bits", {30'd0, ram_e, iar_s}, 32'h2);

        // DATA R0
        for (int s = 4; s <= 6; s++) step($sformatf("data_s%0d", s), 8'h20, s, 1, 1, 4'h0);
        drive(8'h20, 5, 1, 1, 4'h0);
        chk("data_s5_r0s", {31'd0, r0_s}, 32'd1);

        // LD / ST / JMPR / JMP / CLF
        for (int s = 4; s <= 5; s++) step($sformatf("ld_s%0d", s), 8'h06, s, 1, 1, 4'h0);
        for (int s = 4; s <= 5; s++) step($sformatf("st_s%0d", s), 8'h1B, s, 1, 1, 4'h0);
        step("jmpr_s4", 8'h32, 4, 1, 1, 4'h0);
        for (int s = 4; s <= 5; s++) step($sformatf("jmp_s%0d", s), 8'h40, s, 1, 1, 4'h0);
        step("clf_s4", 8'h60, 4, 1, 1, 4'h0);

        // IO
        step("io_out_s4", 8'h7C, 4, 1, 1, 4'h0);
        drive(8'h7C, 4, 1, 1, 4'h0);
`ifdef JCU_IO_EN
        chk("io_7c_bits", {28'd0, io_da, io_io, r0_e, io_s}, 32'hF);
`else
        chk("io_7c_bits", {28'd0, io_da, io_io, r0_e, io_s}, 32'h0);
`endif
        step("io_79_s4", 8'h79, 4, 1, 1, 4'h0);
        step("io_in_s5", 8'h72, 5, 1, 1, 4'h0);

        // Random sweep, halt opcode excluded
        for (int i = 0; i < 400; i++) begin
            rir = 8'($urandom);
            if (rir == 8'h61) rir = 8'h62;
            rst = $urandom_range(1, 6);
            step($sformatf("rand%0d_ir%02h_s%0d", i, rir, rst), rir, rst,
                 1'($urandom), 1'($urandom), 4'($urandom));
        end

        // Halt: non-set step 4 must not halt, clks on step 4 must
        drive(8'h61, 4, 1, 0, 4'h0);
        @(posedge CLK); #1;
        chk("halt_no_clks", {31'd0, halt}, 32'd0);
        drive(8'h61, 4, 1, 1, 4'h0);
        @(posedge CLK); #1;
        halt_m = 1'b1;
        chk("halt_set", {31'd0, halt}, 32'd1);
        for (int s = 1; s <= 3; s++) step($sformatf("halted_fetch_s%0d", s), 8'h81, s, 1, 1, 4'h0);
        drive(8'h81, 1, 1, 1, 4'h0);
        chk("halted_s1_bits", {28'd0, iar_e, bus1_bit1, ram_mar_s, acc_s}, 32'h0);
        @(posedge CLK); #1;
        chk("halt_sticky", {31'd0, halt}, 32'd1);
        #2 reset = 1'b1; #1;
        halt_m = 1'b0;
        chk("halt_async_clear", {31'd0, halt}, 32'd0);
        @(negedge CLK); reset = 1'b0;
        step("after_reset_s1", 8'h81, 1, 1, 1, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
